// File: rtl/battle_turn_ctrl.sv
// rtl/battle_turn_ctrl.sv - two-player battle turn scheduler (optional CRIT_HIT_EN adds doubled-damage crits and a crit output)
module battle_turn_ctrl #(
    parameter logic [7:0] HP_INIT   = 8'd60,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p2_ready,
    output logic [1:0] mux_sel,
    input  logic [3:0] mux_dmg,
    input  logic [3:0] mux_accu,
    output logic [7:0] p1_hp,
    output logic [7:0] p2_hp,
    output logic [1:0] last_hit,
    output logic       turn_done,
    output logic       game_over,
    output logic [1:0] winner
`ifdef CRIT_HIT_EN
    ,
    output logic       crit
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ATK1,
        ATK2,
        DONE,
        OVER
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] p1_hp_q, p1_hp_d;
    logic [7:0] p2_hp_q, p2_hp_d;
    logic [1:0] last_hit_q, last_hit_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] turn_cnt_q, turn_cnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       p1_full_q, p1_full_d;
    logic       p2_full_q, p2_full_d;
    logic [1:0] p1_mv_q, p1_mv_d;
    logic [1:0] p2_mv_q, p2_mv_d;
    logic       p2_first_q, p2_first_d;

    logic       in_atk;
    logic       attacker_p2;
    logic [1:0] atk_move;
    logic [7:0] def_hp;
    logic [3:0] rnd;
    logic       hit;
    logic       crit_hit;
    logic [4:0] dmg;
    logic [7:0] new_hp;
    logic       cap1, cap2;

    // Attack datapath: the second attack of a turn belongs to whoever did not go first.
    always_comb begin
        in_atk      = (state_q == ATK1) || (state_q == ATK2);
        attacker_p2 = (state_q == ATK1) ? p2_first_q : !p2_first_q;
        atk_move    = attacker_p2 ? p2_mv_q : p1_mv_q;
        def_hp      = attacker_p2 ? p1_hp_q : p2_hp_q;
        rnd         = lfsr_q[3:0];
        hit         = (mux_accu == 4'hF) || (rnd < mux_accu);
`ifdef CRIT_HIT_EN
        crit_hit    = hit && (rnd == 4'h0);
`else
        crit_hit    = 1'b0;
`endif
        dmg         = crit_hit ? {mux_dmg, 1'b0} : {1'b0, mux_dmg};
        if (!hit) begin
            new_hp = def_hp;
        end else if (def_hp > {3'b000, dmg}) begin
            new_hp = def_hp - {3'b000, dmg};
        end else begin
            new_hp = 8'd0;
        end
        mux_sel   = in_atk ? atk_move : 2'b00;
        turn_done = (state_q == DONE);
        game_over = (state_q == OVER);
        p1_hp     = p1_hp_q;
        p2_hp     = p2_hp_q;
        last_hit  = last_hit_q;
        winner    = winner_q;
    end

`ifdef CRIT_HIT_EN
    assign crit = in_atk && crit_hit;
`endif

    always_comb begin
        state_d    = state_q;
        p1_hp_d    = p1_hp_q;
        p2_hp_d    = p2_hp_q;
        last_hit_d = last_hit_q;
        winner_d   = winner_q;
        turn_cnt_d = turn_cnt_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        p1_full_d  = p1_full_q;
        p2_full_d  = p2_full_q;
        p1_mv_d    = p1_mv_q;
        p2_mv_d    = p2_mv_q;
        p2_first_d = p2_first_q;
        p1_ready   = 1'b0;
        p2_ready   = 1'b0;
        cap1       = 1'b0;
        cap2       = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    p1_hp_d    = HP_INIT;
                    p2_hp_d    = HP_INIT;
                    turn_cnt_d = 8'd0;
                    winner_d   = 2'b00;
                    last_hit_d = 2'b00;
                    p1_full_d  = 1'b0;
                    p2_full_d  = 1'b0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                p1_ready = !p1_full_q;
                p2_ready = !p2_full_q;
                cap1     = p1_valid && p1_ready;
                cap2     = p2_valid && p2_ready;
                if (cap1) begin
                    p1_full_d = 1'b1;
                    p1_mv_d   = p1_move;
                end
                if (cap2) begin
                    p2_full_d = 1'b1;
                    p2_mv_d   = p2_move;
                end
                // A tie on the capture cycle alternates by turn parity.
                if (cap1 && cap2) begin
                    p2_first_d = turn_cnt_q[0];
                end else if (cap1 && !p2_full_q) begin
                    p2_first_d = 1'b0;
                end else if (cap2 && !p1_full_q) begin
                    p2_first_d = 1'b1;
                end
                if ((p1_full_q || cap1) && (p2_full_q || cap2)) begin
                    state_d = ATK1;
                end
            end
            ATK1, ATK2: begin
                if (attacker_p2) begin
                    p1_hp_d       = new_hp;
                    last_hit_d[1] = hit;
                end else begin
                    p2_hp_d       = new_hp;
                    last_hit_d[0] = hit;
                end
                if (new_hp == 8'd0) begin
                    winner_d = attacker_p2 ? 2'b10 : 2'b01;
                    state_d  = OVER;
                end else begin
                    state_d = (state_q == ATK1) ? ATK2 : DONE;
                end
            end
            DONE: begin
                turn_cnt_d = turn_cnt_q + 8'd1;
                p1_full_d  = 1'b0;
                p2_full_d  = 1'b0;
                state_d    = COLLECT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            p1_hp_q    <= HP_INIT;
            p2_hp_q    <= HP_INIT;
            last_hit_q <= 2'b00;
            winner_q   <= 2'b00;
            turn_cnt_q <= 8'd0;
            lfsr_q     <= LFSR_SEED;
            p1_full_q  <= 1'b0;
            p2_full_q  <= 1'b0;
            p1_mv_q    <= 2'b00;
            p2_mv_q    <= 2'b00;
            p2_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_hp_q    <= p1_hp_d;
            p2_hp_q    <= p2_hp_d;
            last_hit_q <= last_hit_d;
            winner_q   <= winner_d;
            turn_cnt_q <= turn_cnt_d;
            lfsr_q     <= lfsr_d;
            p1_full_q  <= p1_full_d;
            p2_full_q  <= p2_full_d;
            p1_mv_q    <= p1_mv_d;
            p2_mv_q    <= p2_mv_d;
            p2_first_q <= p2_first_d;
        end
    end

endmodule
